// File: rtl/recirc_pkg.sv
// Shared definitions for the recirculation stage.
// Contents: 2-bit mode type and its encodings.
package recirc_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RECIRC  = 2'd1,
    ST_FORWARD = 2'd2,
    ST_UNUSED  = 2'd3
  } mode_t;

endpackage

// File: rtl/recirc_lanes_if.sv
// Lane bus between the packet source, the recirculation stage and the lane FIFOs.
// master: source/tester side (drives lane inputs and FIFO status, observes outputs)
// slave : recirculation stage (consumes lane inputs, drives forward/recirc paths)
interface recirc_lanes_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
);
  logic [LANES-1:0]        valid_in;
  logic [LANES*DATA_W-1:0] data_in;
  logic [LANES-1:0]        fifo_full;
  logic [LANES-1:0]        valid_fwd;
  logic [LANES*DATA_W-1:0] data_fwd;
  logic [LANES-1:0]        valid_recirc;
  logic [LANES*DATA_W-1:0] data_recirc;

  modport master (
    output valid_in, data_in, fifo_full,
    input  valid_fwd, data_fwd, valid_recirc, data_recirc
  );

  modport slave (
    input  valid_in, data_in, fifo_full,
    output valid_fwd, data_fwd, valid_recirc, data_recirc
  );
endinterface

// File: rtl/recirc_lane.sv
// One lane of the recirculation stage: routing decision plus output registers.
// Ports: clk, reset_L (async active-low), active (mode is not RESET), idle,
//        valid/data/full (lane input and FIFO status), take_fwd/take_recirc
//        (combinational routing decision, used for the counters), registered
//        forward and recirculation outputs.
module recirc_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active,
  input  logic              idle,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              full,
  output logic              take_fwd,
  output logic              take_recirc,
  output logic              valid_fwd,
  output logic [DATA_W-1:0] data_fwd,
  output logic              valid_recirc,
  output logic [DATA_W-1:0] data_recirc
);

  // Routing follows the sampled idle, not the mode, so the word arriving
  // with idle rising is forwarded immediately.
  assign take_fwd    = active && valid && idle && !full;
  assign take_recirc = active && valid && !take_fwd;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_fwd    <= 1'b0;
      data_fwd     <= '0;
      valid_recirc <= 1'b0;
      data_recirc  <= '0;
    end else begin
      valid_fwd    <= take_fwd;
      data_fwd     <= take_fwd ? data : '0;
      valid_recirc <= take_recirc;
      data_recirc  <= take_recirc ? data : '0;
    end
  end

endmodule

// File: rtl/recirc_lanes.sv
// Recirculation stage between packet source and per-lane input FIFOs.
// Ports: clk, reset_L (async active-low), idle (1 = forward mode),
//        clear_cnt (sync counter clear), bus (lane bus, slave side),
//        state (current mode), fwd_count/recirc_count (saturating totals).
//
// state      | meaning
// ST_RESET   | first cycle after reset, inputs discarded
// ST_RECIRC  | idle low, all words recirculated
// ST_FORWARD | idle high, words forwarded unless lane FIFO full
// ST_UNUSED  | illegal, recovers to ST_RECIRC
module recirc_lanes
  import recirc_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             idle,
  input  logic             clear_cnt,
  recirc_lanes_if.slave    bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] fwd_count,
  output logic [CNT_W-1:0] recirc_count
);

  localparam int PW = $clog2(LANES + 1);

  mode_t state_q, state_d;

  logic [LANES-1:0]        take_fwd, take_recirc;
  logic [LANES-1:0]        vf_q, vr_q;
  logic [LANES*DATA_W-1:0] df_q, dr_q;
  logic [PW-1:0]           fwd_pop, recirc_pop;
  logic [CNT_W:0]          fwd_sum, recirc_sum;
  logic [CNT_W-1:0]        fwd_cnt_q, recirc_cnt_q;
  logic                    active;

  assign active = (state_q != ST_RESET);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RECIRC;
    case (state_q)
      ST_RESET:   state_d = ST_RECIRC;
      ST_RECIRC:  state_d = idle ? ST_FORWARD : ST_RECIRC;
      ST_FORWARD: state_d = idle ? ST_FORWARD : ST_RECIRC;
      default:    state_d = ST_RECIRC;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    recirc_lane #(.DATA_W(DATA_W)) u_lane (
      .clk          (clk),
      .reset_L      (reset_L),
      .active       (active),
      .idle         (idle),
      .valid        (bus.valid_in[i]),
      .data         (bus.data_in[i*DATA_W +: DATA_W]),
      .full         (bus.fifo_full[i]),
      .take_fwd     (take_fwd[i]),
      .take_recirc  (take_recirc[i]),
      .valid_fwd    (vf_q[i]),
      .data_fwd     (df_q[i*DATA_W +: DATA_W]),
      .valid_recirc (vr_q[i]),
      .data_recirc  (dr_q[i*DATA_W +: DATA_W])
    );
  end

  assign bus.valid_fwd    = vf_q;
  assign bus.data_fwd     = df_q;
  assign bus.valid_recirc = vr_q;
  assign bus.data_recirc  = dr_q;

  always_comb begin
    fwd_pop    = '0;
    recirc_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      fwd_pop    = fwd_pop + PW'(take_fwd[i]);
      recirc_pop = recirc_pop + PW'(take_recirc[i]);
    end
  end

  // One extra bit catches the carry; a set carry means saturate.
  assign fwd_sum    = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_pop);
  assign recirc_sum = {1'b0, recirc_cnt_q} + (CNT_W+1)'(recirc_pop);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fwd_cnt_q    <= '0;
      recirc_cnt_q <= '0;
    end else if (clear_cnt) begin
      fwd_cnt_q    <= '0;
      recirc_cnt_q <= '0;
    end else begin
      fwd_cnt_q    <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
      recirc_cnt_q <= recirc_sum[CNT_W] ? '1 : recirc_sum[CNT_W-1:0];
    end
  end

  assign state        = state_q;
  assign fwd_count    = fwd_cnt_q;
  assign recirc_count = recirc_cnt_q;

endmodule

// File: tb/tb_recirc_lanes.sv
// Self-checking bench for recirc_lanes (LANES=4, DATA_W=8, CNT_W=4 so that
// saturation is reachable quickly). Expected outputs are pushed to a queue
// when each step is driven and popped one edge later for comparison.
module tb_recirc_lanes;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [3:0]  vf;
    logic [3:0]  vr;
    logic [31:0] df;
    logic [31:0] dr;
    logic [1:0]  st;
    logic [3:0]  fc;
    logic [3:0]  rc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic idle = 1'b0;
  logic clear_cnt = 1'b0;
  logic [1:0] state;
  logic [CNT_W-1:0] fwd_count, recirc_count;

  recirc_lanes_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  recirc_lanes #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .idle         (idle),
    .clear_cnt    (clear_cnt),
    .bus          (bus),
    .state        (state),
    .fwd_count    (fwd_count),
    .recirc_count (recirc_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  exp_t sb[$];

  // Reference model state
  logic [1:0] m_st = 2'd0;
  logic [3:0] m_fc = 4'd0;
  logic [3:0] m_rc = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] sat_add(input logic [3:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > 15) ? 4'd15 : 4'(s);
  endfunction

  // Drive one cycle of input, predict, clock, then compare the popped result.
  task automatic step(input string tag, input logic id, input logic [3:0] v,
                      input logic [3:0] ff, input logic [31:0] d, input logic clr);
    exp_t e;
    int nf, nr;
    idle          = id;
    bus.valid_in  = v;
    bus.fifo_full = ff;
    bus.data_in   = d;
    clear_cnt     = clr;
    e.vf = 4'h0; e.vr = 4'h0; e.df = 32'h0; e.dr = 32'h0;
    nf = 0; nr = 0;
    if (m_st != 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (id && !ff[i]) begin
            e.vf[i] = 1'b1;
            e.df[i*8 +: 8] = d[i*8 +: 8];
            nf++;
          end else begin
            e.vr[i] = 1'b1;
            e.dr[i*8 +: 8] = d[i*8 +: 8];
            nr++;
          end
        end
      end
    end
    m_fc = clr ? 4'd0 : sat_add(m_fc, nf);
    m_rc = clr ? 4'd0 : sat_add(m_rc, nr);
    m_st = (m_st == 2'd0) ? 2'd1 : (id ? 2'd2 : 2'd1);
    e.st = m_st; e.fc = m_fc; e.rc = m_rc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid_fwd"},    32'(bus.valid_fwd),    32'(e.vf));
      chk({tag, ".valid_recirc"}, 32'(bus.valid_recirc), 32'(e.vr));
      chk({tag, ".data_fwd"},     bus.data_fwd,          e.df);
      chk({tag, ".data_recirc"},  bus.data_recirc,       e.dr);
      chk({tag, ".state"},        32'(state),            32'(e.st));
      chk({tag, ".fwd_count"},    32'(fwd_count),        32'(e.fc));
      chk({tag, ".recirc_count"}, 32'(recirc_count),     32'(e.rc));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid_fwd"},    32'(bus.valid_fwd),    32'h0);
    chk({tag, ".valid_recirc"}, 32'(bus.valid_recirc), 32'h0);
    chk({tag, ".data_fwd"},     bus.data_fwd,          32'h0);
    chk({tag, ".data_recirc"},  bus.data_recirc,       32'h0);
    chk({tag, ".state"},        32'(state),            32'h0);
    chk({tag, ".fwd_count"},    32'(fwd_count),        32'h0);
    chk({tag, ".recirc_count"}, 32'(recirc_count),     32'h0);
  endtask

  initial begin
    bus.valid_in  = '0;
    bus.data_in   = '0;
    bus.fifo_full = '0;

    // Reset values
    #12;
    chk_zero("reset");
    #5 reset_L = 1'b1;
    @(posedge clk); #1;   // wait is not needed for model; align to edge+1
    // The edge above was the RESET cycle edge; redo this cleanly with a step
    // would double-count, so check the recovery explicitly instead.
    chk("first_edge.state", 32'(state), 32'd1);
    chk("first_edge.valid_fwd", 32'(bus.valid_fwd), 32'h0);
    m_st = 2'd1;

    // Fresh reset with valid words present during the RESET cycle
    reset_L = 1'b0; #2; reset_L = 1'b1;
    m_st = 2'd0; m_fc = 4'd0; m_rc = 4'd0;
    step("reset_cycle", 1'b0, 4'hF, 4'h0, 32'hA5A5A5A5, 1'b0);

    // Forward burst: idle rising, first word already forwarded
    step("fwd1", 1'b1, 4'hF, 4'h0, 32'h00000000, 1'b0);
    step("fwd2", 1'b1, 4'hF, 4'h0, 32'h00000101, 1'b0);

    // Backpressure on lane 2
    step("clr_a", 1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    step("bp", 1'b1, 4'hF, 4'b0100, 32'h01010000, 1'b0);
    step("bp_mixed", 1'b1, 4'b1010, 4'b1001, 32'h11223344, 1'b0);

    // Mode drop with all lanes valid
    step("drop", 1'b0, 4'hF, 4'h0, 32'hDEADBEEF, 1'b0);
    step("recirc", 1'b0, 4'b0101, 4'hF, 32'h0F0E0D0C, 1'b0);

    // Saturation then clear (clear wins over concurrent words)
    step("clr_b", 1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++)
      step("sat", 1'b1, 4'hF, 4'h0, $urandom, 1'b0);
    step("clr_sat", 1'b1, 4'hF, 4'h0, 32'h12345678, 1'b1);

    // Some randomised steps
    for (int k = 0; k < 12; k++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom, 1'b0);

    // Reset mid-burst: outputs drop without a clock edge
    step("pre_rst", 1'b1, 4'hF, 4'h0, 32'h55AA55AA, 1'b0);
    #2 reset_L = 1'b0;
    #1;
    chk_zero("mid_reset");
    #3 reset_L = 1'b1;
    m_st = 2'd0; m_fc = 4'd0; m_rc = 4'd0;
    step("post_rst", 1'b1, 4'hF, 4'h0, 32'h77777777, 1'b0);
    step("post_rst2", 1'b1, 4'hF, 4'b0001, 32'h01020304, 1'b0);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule

// File: doc/recirc_lanes.md
# recirc_lanes

Parametrised recirculation stage that sits between the packet source/tester and the per-lane input FIFOs. Each cycle, every valid input word is routed either forward to its lane FIFO or back to the source on the recirculation path, based on the global `idle` mode and per-lane FIFO backpressure. Words are never dropped. Saturating forward and recirculation word counters support bench scoreboarding.

## Interface
- `LANES`, 4, number of lanes.
- `DATA_W`, 8, word width per lane.
- `CNT_W`, 16, width of each statistics counter.

- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `idle`  in  1  1 = forward mode, 0 = recirculate everything.
- `valid_in`  in  LANES  per-lane input valid.
- `data_in`  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- `fifo_full`  in  LANES  per-lane downstream FIFO full or almost-full.
- `clear_cnt`  in  1  synchronous clear of both counters.
- `valid_fwd`  out  LANES  forward-path valid, to lane FIFOs.
- `data_fwd`  out  LANES*DATA_W  forward-path data.
- `valid_recirc`  out  LANES  recirculation-path valid, to source.
- `data_recirc`  out  LANES*DATA_W  recirculation-path data.
- `state`  out  2  current mode: RESET=0, RECIRC=1, FORWARD=2.
- `fwd_count`  out  CNT_W  total words forwarded, saturating.
- `recirc_count`  out  CNT_W  total words recirculated, saturating.

## Operation
- **Mode FSM**
  - RESET goes to RECIRC on the first edge after `reset_L` rises, regardless of inputs.
  - RECIRC goes to FORWARD when `idle`=1 is sampled.
  - FORWARD goes to RECIRC when `idle`=0 is sampled.
  - Encoding 3 is unused and recovers to RECIRC.
- **Routing**, evaluated at each edge with lane inputs and `idle` sampled at that edge:
  - If `state`=RESET, all inputs are ignored and all valids are 0 next cycle.
  - Otherwise, a valid word on lane i goes forward when `idle`=1 and `fifo_full[i]`=0.
  - In every other case the word goes to the recirculation path.
  - Routing uses the sampled `idle`, not `state`, so the first word accompanying `idle` rising is already forwarded.
- **Exclusivity:** per lane, at most one of `valid_fwd[i]` and `valid_recirc[i]` is 1. An invalid input produces neither.
- **Data on non-valid paths:** forced to 0, never held. A bench compares data only when the corresponding valid is set.
- **Counters**
  - Each cycle, `fwd_count` adds popcount(forwarded lanes) and `recirc_count` adds popcount(recirculated lanes).
  - Both counters saturate at 2^CNT_W−1 and never wrap.
  - `clear_cnt`=1 loads 0 and discards that cycle's increments.
- **Mid-operation reset:** `reset_L` low immediately clears all outputs, with in-flight words discarded.

## Timing
- Latency is exactly 1 cycle, input edge to output edge. All outputs are registered.
- Throughput is LANES words per cycle with no bubbles.
- `state` and the counters update on the same edge as the routed data they describe.
- **Reset values:** all valids 0, all data 0, `state`=0 (RESET), both counters 0.
- **Backpressure:** `fifo_full` is sampled with the data. A lane that becomes full mid-burst diverts its word in that same cycle, while the other lanes are unaffected.
- **Simultaneous events:**
  - `idle` falling with valid words present: those words are recirculated.
  - `clear_cnt` together with saturation: clear wins.

## Structure
- **Shared package `recirc_pkg`:** state encodings `ST_RESET`, `ST_RECIRC`, `ST_FORWARD`, and the 2-bit state type.
- **Sub-module `recirc_lane`:** the per-lane routing decision plus output registers, instantiated LANES times in a generate loop.
- **Top level:** holds the FSM, the popcounts and the saturating counters.

## Test plan
- **Reset and first edge:** reset, then `valid_in`=4'hF, `idle`=0 during the RESET cycle → no output valids; `state` becomes 1.
- **Forward burst:** `idle`=1, `fifo_full`=0, data lanes 0–3 = 8'h00 then 8'h01,8'h01,8'h00,8'h00 → next cycle `valid_fwd`=4'hF with matching data; `fwd_count` reaches 8 after two cycles; `state`=2.
- **Backpressure:** `idle`=1, `fifo_full`=4'b0100, data 8'h00,8'h00,8'h01,8'h01 → `valid_fwd`=4'b1011 and `valid_recirc`=4'b0100 (data 8'h01); `recirc_count` +1, `fwd_count` +3.
- **Mode drop:** `idle` falls with `valid_in`=4'hF → all four words on the recirculation path next cycle; `state` returns to 1; `data_fwd`=0.
- **Saturation and clear:** with `CNT_W`=4, forward 5 full cycles → `fwd_count`=15 (no wrap); assert `clear_cnt` → 0.
- **Reset mid-burst:** drop `reset_L` with valids high → outputs are 0 immediately, without waiting for a clock edge; after release, the RESET cycle discards input.
